// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet-style framer pair: state encodings,
// framing constants, CRC-32 parameters and field lengths.
package eth_pkg;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StPreamble = 4'd1,
        StDest     = 4'd2,
        StSrc      = 4'd3,
        StType     = 4'd4,
        StData     = 4'd5,
        StFcs      = 4'd6,
        StDone     = 4'd7,
        StDrop     = 4'd8
    } eth_state_e;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    localparam int unsigned DEST_LEN = 6;
    localparam int unsigned SRC_LEN  = 6;
    localparam int unsigned TYPE_LEN = 2;
    localparam int unsigned DATA_LEN = 4;
    localparam int unsigned FCS_LEN  = 4;

    // Index of the final byte of the field handled in state s.
    function automatic logic [2:0] field_last(input eth_state_e s);
        case (s)
            StDest:  return 3'(DEST_LEN - 1);
            StSrc:   return 3'(SRC_LEN - 1);
            StType:  return 3'(TYPE_LEN - 1);
            StData:  return 3'(DATA_LEN - 1);
            StFcs:   return 3'(FCS_LEN - 1);
            default: return 3'd0;
        endcase
    endfunction

    // Field that follows s on the wire.
    function automatic eth_state_e next_field(input eth_state_e s);
        case (s)
            StDest:  return StSrc;
            StSrc:   return StType;
            StType:  return StData;
            StData:  return StFcs;
            default: return StDone;
        endcase
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte CRC-32 step: MSB first, non-reflected.
module crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    // Eight serial LFSR steps unrolled into one combinational cone.
    always_comb begin
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ byte_in[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC32_POLY;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/frame_reception.sv
// Receive-side framer: locks on preamble/SFD, deserialises header and payload,
// checks the FCS and publishes decoded fields with a one-cycle rx_done.
module frame_reception
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_MAX = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_en,
    input  logic [7:0]  rx_in,
    output logic [47:0] dest_addr,
    output logic [47:0] src_addr,
    output logic [15:0] eth_type,
    output logic [31:0] data_out,
    output logic        rx_done,
    output logic        crc_err,
    output logic        frame_err,
    output logic [3:0]  state,
    output logic [2:0]  byte_count
);

    eth_state_e   state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [31:0]  crc_q, crc_d, crc_next;
    // dest(48) | src(48) | type(16) | data(32), shifted in wire order
    logic [143:0] hdr_q, hdr_d;
    // first three FCS bytes; the fourth is taken straight from rx_in
    logic [23:0]  fcs_q, fcs_d;
    logic         frame_err_q, frame_err_d;
    logic         publish;
    logic         last_byte;

    crc32_byte u_crc (
        .crc_in  (crc_q),
        .byte_in (rx_in),
        .crc_out (crc_next)
    );

    // Next-state, shadow shifting and CRC accumulation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        hdr_d       = hdr_q;
        fcs_d       = fcs_q;
        frame_err_d = 1'b0;
        publish     = 1'b0;
        last_byte   = (cnt_q == field_last(state_q));

        unique case (state_q)
            StIdle: begin
                if (rx_en) begin
                    state_d = (rx_in == ETH_PREAMBLE) ? StPreamble : StDrop;
                end
            end
            StPreamble: begin
                // cnt_q + 1 preamble bytes have been seen so far
                if (!rx_en) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else if (rx_in == ETH_SFD) begin
                    crc_d   = CRC32_INIT;
                    state_d = StDest;
                end else if (rx_in == ETH_PREAMBLE &&
                             (32'(cnt_q) + 32'd2) <= PREAMBLE_MAX) begin
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = StDrop;
                end
            end
            StDest, StSrc, StType, StData: begin
                if (!rx_en) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    hdr_d = {hdr_q[135:0], rx_in};
                    crc_d = crc_next;
                    if (last_byte) begin
                        state_d = next_field(state_q);
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StFcs: begin
                if (!rx_en) begin
                    frame_err_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    fcs_d = {fcs_q[15:0], rx_in};
                    if (last_byte) begin
                        publish = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            StDone: begin
                state_d = rx_en ? StDrop : StIdle;
            end
            StDrop: begin
                if (!rx_en) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = 3'd0;
        end
    end

    // Control and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            crc_q       <= CRC32_INIT;
            hdr_q       <= '0;
            fcs_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            hdr_q       <= hdr_d;
            fcs_q       <= fcs_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Published fields load only on entry to DONE; aborts leave them intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dest_addr <= '0;
            src_addr  <= '0;
            eth_type  <= '0;
            data_out  <= '0;
            crc_err   <= 1'b0;
        end else if (publish) begin
            dest_addr <= hdr_q[143:96];
            src_addr  <= hdr_q[95:48];
            eth_type  <= hdr_q[47:32];
            data_out  <= hdr_q[31:0];
            crc_err   <= ({fcs_q, rx_in} != ~crc_q);
        end
    end

    assign rx_done    = (state_q == StDone);
    assign frame_err  = frame_err_q;
    assign state      = state_q;
    assign byte_count = cnt_q;

endmodule
